// File: rtl/c4_pkg.sv
// rtl/c4_pkg.sv - shared types and constants for the coin drop controller
package c4_pkg;

  localparam int ROWS_DEF    = 6;
  localparam int COLS_DEF    = 7;
  localparam int WADDR_BASE  = 31;
  localparam int WADDR_PITCH = 4;

  typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_WINCHK, ST_TURN, ST_OVER} state_t;
  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D1, DIR_D2} dir_t;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  // Bottom board line sits at the highest grid address; each row up is one pitch lower.
  function automatic logic [4:0] row_to_waddr(input logic [2:0] row);
    return 5'(WADDR_BASE - WADDR_PITCH * int'(row));
  endfunction

  function automatic logic signed [3:0] dir_dr(input dir_t d);
    return (d == DIR_H) ? 4'sd0 : 4'sd1;
  endfunction

  function automatic logic signed [3:0] dir_dc(input dir_t d);
    case (d)
      DIR_V:   return 4'sd0;
      DIR_D2:  return -4'sd1;
      default: return 4'sd1;
    endcase
  endfunction

endpackage

// File: rtl/coin_drop_ctrl_if.sv
// rtl/coin_drop_ctrl_if.sv - drop request, grid write strobe and game status bundle
interface coin_drop_ctrl_if;

  logic       drop;
  logic [2:0] col;
  logic       wen;
  logic [4:0] waddr;
  logic [2:0] colval;
  logic       Player;
  logic       win1;
  logic       win2;
  logic       draw;
  logic       busy;
  logic       reject;

  modport master (
    output drop, col,
    input  wen, waddr, colval, Player, win1, win2, draw, busy, reject
  );

  modport slave (
    input  drop, col,
    output wen, waddr, colval, Player, win1, win2, draw, busy, reject
  );

endinterface

// File: rtl/c4_line_scan.sv
// rtl/c4_line_scan.sv - walks one direction from the placed coin, one neighbour per cycle
module c4_line_scan
  import c4_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  dir_t                   dir,
  input  logic signed [3:0]      orow,
  input  logic signed [3:0]      ocol,
  input  logic [2*ROWS*COLS-1:0] board,
  output logic                   done,
  output logic [2:0]             count
);

  localparam logic signed [3:0] ROWS4 = 4'(ROWS);
  localparam logic signed [3:0] COLS4 = 4'(COLS);

  dir_t              dir_q;
  logic              active;
  logic              side;
  logic [1:0]        k;
  logic [2:0]        cnt;
  logic signed [3:0] nr, nc;
  logic signed [3:0] dr, dc, sdr, sdc;
  logic              inb, match, side_end;
  logic [1:0]        origin_cell;

  function automatic logic [1:0] cell_at(input logic [3:0] r, input logic [3:0] c);
    int i;
    i = int'(r) * COLS + int'(c);
    return board[2*i +: 2];
  endfunction

  // Positions that overflow the signed range wrap negative, so the sign bit alone flags them out.
  always_comb begin
    dr          = dir_dr(dir_q);
    dc          = dir_dc(dir_q);
    sdr         = side ? -dr : dr;
    sdc         = side ? -dc : dc;
    origin_cell = cell_at(orow, ocol);
    inb         = !nr[3] && !nc[3] && (nr < ROWS4) && (nc < COLS4);
    match       = 1'b0;
    if (inb) match = (cell_at(nr, nc) == origin_cell);
    count    = cnt + {2'b00, match};
    side_end = !match || (k == 2'd3);
    done     = active && ((count >= 3'd4) || (side_end && side));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q  <= DIR_H;
      active <= 1'b0;
      side   <= 1'b0;
      k      <= 2'd1;
      cnt    <= 3'd1;
      nr     <= '0;
      nc     <= '0;
    end else if (start) begin
      dir_q  <= dir;
      active <= 1'b1;
      side   <= 1'b0;
      k      <= 2'd1;
      cnt    <= 3'd1;
      nr     <= orow + dir_dr(dir);
      nc     <= ocol + dir_dc(dir);
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end else begin
        cnt <= count;
        if (side_end) begin
          side <= 1'b1;
          k    <= 2'd1;
          nr   <= orow - dr;
          nc   <= ocol - dc;
        end else begin
          k  <= k + 2'd1;
          nr <= nr + sdr;
          nc <= nc + sdc;
        end
      end
    end
  end

endmodule

// File: rtl/coin_drop_ctrl.sv
// rtl/coin_drop_ctrl.sv - connect-four style coin drop controller with grid write and win/draw detection
module coin_drop_ctrl
  import c4_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  coin_drop_ctrl_if.slave bus
);

  localparam int NCELL = ROWS * COLS;

  state_t             state, state_n;
  dir_t               dir_q, scan_dir;
  logic               scan_start, scan_done;
  logic [2:0]         scan_count;
  logic [2*NCELL-1:0] board;
  logic [2:0]         height [COLS];
  logic [2:0]         row, colq, h_sel;
  logic               col_ok, accept, all_full;
  logic               win_hit, last_dir;
  logic               player;
  logic [4:0]         waddr;
  logic [2:0]         colval;
  logic               win1, win2, draw, reject;

  always_comb begin
    col_ok = 1'b0;
    h_sel  = 3'(ROWS);
    for (int c = 0; c < COLS; c++) begin
      if (bus.col == 3'(c)) begin
        col_ok = 1'b1;
        h_sel  = height[c];
      end
    end
    accept   = col_ok && (h_sel < 3'(ROWS));
    all_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (height[c] != 3'(ROWS)) all_full = 1'b0;
    end
    win_hit  = scan_done && (scan_count >= 3'd4);
    last_dir = (dir_q == DIR_D2);
  end

  always_comb begin
    state_n    = state;
    scan_start = 1'b0;
    scan_dir   = dir_q;
    case (state)
      ST_IDLE:   if (bus.drop && accept) state_n = ST_WRITE;
      ST_WRITE: begin
        state_n    = ST_WINCHK;
        scan_start = 1'b1;
        scan_dir   = DIR_H;
      end
      ST_WINCHK: begin
        if (win_hit) begin
          state_n = ST_OVER;
        end else if (scan_done) begin
          if (last_dir) begin
            state_n = all_full ? ST_OVER : ST_TURN;
          end else begin
            scan_start = 1'b1;
            scan_dir   = dir_t'(dir_q + 2'd1);
          end
        end
      end
      ST_TURN:   state_n = ST_IDLE;
      ST_OVER:   state_n = ST_OVER;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board <= {NCELL{CELL_EMPTY}};
      for (int c = 0; c < COLS; c++) height[c] <= '0;
      row    <= '0;
      colq   <= '0;
      dir_q  <= DIR_H;
      player <= 1'b1;
      waddr  <= row_to_waddr(3'd0);
      colval <= '0;
      win1   <= 1'b0;
      win2   <= 1'b0;
      draw   <= 1'b0;
      reject <= 1'b0;
    end else begin
      reject <= 1'b0;
      if (scan_start) dir_q <= scan_dir;
      case (state)
        ST_IDLE: begin
          if (bus.drop) begin
            if (accept) begin
              row    <= h_sel;
              colq   <= bus.col;
              waddr  <= row_to_waddr(h_sel);
              colval <= bus.col;
            end else begin
              reject <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          board[2*(int'(row)*COLS + int'(colq)) +: 2] <= player ? CELL_P1 : CELL_P2;
          for (int c = 0; c < COLS; c++) begin
            if (colq == 3'(c)) height[c] <= height[c] + 3'd1;
          end
        end
        ST_WINCHK: begin
          if (win_hit) begin
            win1 <= player;
            win2 <= !player;
          end else if (scan_done && last_dir && all_full) begin
            draw <= 1'b1;
          end
        end
        ST_TURN: player <= !player;
        default: ;
      endcase
    end
  end

  c4_line_scan #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .start (scan_start),
    .dir   (scan_dir),
    .orow  (signed'({1'b0, row})),
    .ocol  (signed'({1'b0, colq})),
    .board (board),
    .done  (scan_done),
    .count (scan_count)
  );

  assign bus.wen    = (state == ST_WRITE);
  assign bus.busy   = (state != ST_IDLE);
  assign bus.waddr  = waddr;
  assign bus.colval = colval;
  assign bus.Player = player;
  assign bus.win1   = win1;
  assign bus.win2   = win2;
  assign bus.draw   = draw;
  assign bus.reject = reject;

endmodule

// File: tb/tb_coin_drop_ctrl.sv
// tb/tb_coin_drop_ctrl.sv - directed scoreboard bench for coin_drop_ctrl
module tb_coin_drop_ctrl;

  typedef struct {
    logic [4:0] waddr;
    logic [2:0] colval;
    logic       player;
  } wr_t;

  logic clk;
  logic rst;
  coin_drop_ctrl_if bus ();

  coin_drop_ctrl #(.ROWS(6), .COLS(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  wr_t sb[$];

  int  mb [6][7];
  int  mh [7];
  bit  m_player, m_over, ew1, ew2, ed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every grid write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.wen === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_wen", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wen_waddr", bus.waddr, e.waddr);
        check("wen_colval", bus.colval, e.colval);
        check("wen_player", bus.Player, e.player);
      end
    end
  end

  function automatic int run_len(int r, int c, int dr, int dc);
    int n, rr, cc, v;
    v = mb[r][c];
    n = 1;
    rr = r + dr; cc = c + dc;
    while (rr >= 0 && rr < 6 && cc >= 0 && cc < 7 && mb[rr][cc] == v) begin
      n++; rr += dr; cc += dc;
    end
    rr = r - dr; cc = c - dc;
    while (rr >= 0 && rr < 6 && cc >= 0 && cc < 7 && mb[rr][cc] == v) begin
      n++; rr -= dr; cc -= dc;
    end
    return n;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) mb[r][c] = 0;
    for (int c = 0; c < 7; c++) mh[c] = 0;
    m_player = 1'b1; m_over = 1'b0; ew1 = 1'b0; ew2 = 1'b0; ed = 1'b0;
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wen"}, bus.wen, 0);
    check({tag, "_waddr"}, bus.waddr, 31);
    check({tag, "_colval"}, bus.colval, 0);
    check({tag, "_player"}, bus.Player, 1);
    check({tag, "_win1"}, bus.win1, 0);
    check({tag, "_win2"}, bus.win2, 0);
    check({tag, "_draw"}, bus.draw, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_reject"}, bus.reject, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; bus.drop = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    model_clear();
  endtask

  task automatic do_drop(input int c);
    bit acc, was_over, win, full, fin;
    int r, lat;
    was_over = m_over;
    acc = !m_over && (c < 7) && (mh[c] < 6);
    win = 1'b0;
    full = 1'b0;
    if (acc) begin
      r = mh[c];
      sb.push_back('{5'(31 - 4*r), 3'(c), m_player});
      mb[r][c] = m_player ? 1 : 2;
      mh[c]++;
      win = (run_len(r, c, 0, 1) >= 4) || (run_len(r, c, 1, 0) >= 4) ||
            (run_len(r, c, 1, 1) >= 4) || (run_len(r, c, 1, -1) >= 4);
      full = 1'b1;
      for (int i = 0; i < 7; i++) if (mh[i] != 6) full = 1'b0;
    end
    @(negedge clk);
    bus.drop = 1'b1; bus.col = 3'(c);
    @(negedge clk);
    bus.drop = 1'b0;
    check("wen_after_drop", bus.wen, acc);
    check("reject_pulse", bus.reject, !was_over && !acc);
    if (acc) begin
      lat = 1;
      fin = 1'b0;
      for (int i = 0; i < 40 && !fin; i++) begin
        @(negedge clk);
        lat++;
        if (!bus.busy || bus.win1 || bus.win2 || bus.draw) fin = 1'b1;
      end
      check("drop_completes", fin, 1);
      check("latency_le_27", lat <= 27, 1);
      if (win) begin
        m_over = 1'b1; ew1 = m_player; ew2 = !m_player;
      end else if (full) begin
        m_over = 1'b1; ed = 1'b1;
      end else begin
        m_player = !m_player;
      end
      check("win1", bus.win1, ew1);
      check("win2", bus.win2, ew2);
      check("draw", bus.draw, ed);
      check("player", bus.Player, m_player);
      check("busy", bus.busy, m_over);
    end else begin
      @(negedge clk);
      check("reject_one_cycle", bus.reject, 0);
      check("no_wen", bus.wen, 0);
      check("player_hold", bus.Player, m_player);
      check("busy_hold", bus.busy, m_over);
    end
  endtask

  initial begin
    int fill_seq[$];
    int pa[3];
    int pb[3];
    rst = 1'b1; bus.drop = 1'b0; bus.col = 3'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    model_clear();

    // invalid column
    do_drop(7);

    // vertical four for player 1
    do_drop(0); do_drop(1); do_drop(0); do_drop(1); do_drop(0); do_drop(1); do_drop(0);
    check("vert_win1", bus.win1, 1);
    do_drop(4);

    // horizontal four on the bottom row
    apply_reset();
    do_drop(0); do_drop(6); do_drop(1); do_drop(6); do_drop(2); do_drop(6); do_drop(3);
    check("horiz_win1", bus.win1, 1);
    do_drop(5);

    // column overflow
    apply_reset();
    repeat (7) do_drop(2);

    // reset in the middle of the win check
    apply_reset();
    sb.push_back('{5'd31, 3'd3, 1'b1});
    @(negedge clk);
    bus.drop = 1'b1; bus.col = 3'd3;
    @(negedge clk);
    bus.drop = 1'b0;
    @(negedge clk);
    check("winchk_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    model_clear();
    do_drop(3);

    // full board with no winner
    apply_reset();
    pa = '{0, 1, 4};
    pb = '{2, 3, 6};
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 3; k++) begin
        fill_seq.push_back(pa[p]); fill_seq.push_back(pb[p]);
        fill_seq.push_back(pb[p]); fill_seq.push_back(pa[p]);
      end
    repeat (6) fill_seq.push_back(5);
    foreach (fill_seq[i]) do_drop(fill_seq[i]);
    check("draw_final", bus.draw, 1);
    check("draw_no_win1", bus.win1, 0);
    check("draw_no_win2", bus.win2, 0);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
